cmac_tag_verifier: RTL

- Receive side of the AES-CMAC path: recomputes the CMAC of an incoming message and checks it against a received tag.
- Message arrives as 128-bit blocks over a valid/ready stream; the expected tag is latched at start.
- Block encryptions are issued to a shared AES-128 encrypt engine, which holds the key, through a req/ack handshake.
- Produces a one-cycle verdict pulse with pass/fail and the computed tag.

---
 rtl/cmac_tag_verifier.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cmac_tag_verifier.sv
// Receive-side AES-CMAC check: derives subkeys, chains message blocks through a
// shared AES-128 engine, and compares the resulting MAC against a latched tag.
module cmac_tag_verifier #(
  parameter int           TAG_BYTES = 16,
  parameter logic [127:0] RB        = 128'h87
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] exp_tag,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [127:0] msg_data,
  input  logic         msg_last,
  input  logic [4:0]   msg_bytes,
  output logic         aes_req,
  output logic [127:0] aes_din,
  input  logic         aes_ack,
  input  logic [127:0] aes_dout,
  output logic         busy,
  output logic         result_valid,
  output logic         tag_ok,
  output logic [127:0] computed_tag
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SUBKEY   = 3'd1;
  localparam logic [2:0] WAIT_BLK = 3'd2;
  localparam logic [2:0] ENC      = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam int CMP_W = 8 * TAG_BYTES;

  logic [2:0]   state_reg;
  logic [127:0] x_reg;
  logic [127:0] l_reg;
  logic [127:0] k1_reg;
  logic [127:0] k2_reg;
  logic [127:0] exp_reg;
  logic [127:0] din_reg;
  logic [127:0] computed_reg;
  logic         last_reg;
  logic         tag_ok_reg;

  logic [127:0] pad_data;
  logic [127:0] block_in;
  logic [127:0] k1_next;
  logic         full_block;
  logic         tag_match;

  function automatic logic [127:0] dbl(input logic [127:0] v);
    return {v[126:0], 1'b0} ^ (v[127] ? RB : 128'h0);
  endfunction

  // Byte 0 sits in the top byte; bytes past the valid count become 80 00 .. 00.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pad
      assign pad_data[127-8*gi -: 8] =
        (msg_bytes > 5'(gi))  ? msg_data[127-8*gi -: 8] :
        (msg_bytes == 5'(gi)) ? 8'h80 : 8'h00;
    end
  endgenerate

  // Any count of 16 or more on a last block is a complete block.
  assign full_block = msg_bytes[4];
  assign block_in   = !msg_last  ? msg_data :
                      full_block ? (msg_data ^ k1_reg) : (pad_data ^ k2_reg);
  assign k1_next    = dbl(aes_dout);
  assign tag_match  = (aes_dout[127 -: CMP_W] == exp_reg[127 -: CMP_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      l_reg        <= '0;
      k1_reg       <= '0;
      k2_reg       <= '0;
      exp_reg      <= '0;
      din_reg      <= '0;
      computed_reg <= '0;
      last_reg     <= 1'b0;
      tag_ok_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            exp_reg      <= exp_tag;
            din_reg      <= '0;
            computed_reg <= '0;
            tag_ok_reg   <= 1'b0;
            state_reg    <= SUBKEY;
          end
        end
        SUBKEY: begin
          if (aes_ack) begin
            l_reg     <= aes_dout;
            k1_reg    <= k1_next;
            k2_reg    <= dbl(k1_next);
            x_reg     <= '0;
            state_reg <= WAIT_BLK;
          end
        end
        WAIT_BLK: begin
          if (msg_valid) begin
            din_reg   <= x_reg ^ block_in;
            last_reg  <= msg_last;
            state_reg <= ENC;
          end
        end
        ENC: begin
          if (aes_ack) begin
            x_reg <= aes_dout;
            if (last_reg) begin
              computed_reg <= aes_dout;
              tag_ok_reg   <= tag_match;
              state_reg    <= DONE;
            end else begin
              state_reg <= WAIT_BLK;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign msg_ready    = (state_reg == WAIT_BLK);
  assign aes_req      = (state_reg == SUBKEY) || (state_reg == ENC);
  assign aes_din      = din_reg;
  assign busy         = (state_reg != IDLE);
  assign result_valid = (state_reg == DONE);
  assign tag_ok       = tag_ok_reg;
  assign computed_tag = computed_reg;

endmodule
